// File: rtl/dds_ftw_writer.sv
// ---------------------------------------------------------------------------
// dds_ftw_writer
//
// Takes the 32-bit frequency tuning word coming from the serial-frame reader
// (asynchronous to CLK_FPGA), synchronizes it, waits until it has been stable
// for STABLE_CYCLES samples, and when it differs from the last word written
// shifts {FTW_ADDR, FTW} (40 bits, MSB first) into the DDS serial port,
// followed by an I/O update strobe.
//
// Optional feature macro: DDS_IOUPDATE_EN
//   defined   -> IOUPD state present, DDS_IOUPDATE pulsed after each frame
//   undefined -> DDS_IOUPDATE tied low, GAP returns straight to IDLE
//
// Ports:
//   CLK_FPGA      in   system clock, rising edge
//   RST_N         in   asynchronous active-low reset
//   FTWhigh_32bit in   tuning word from the reader (async domain)
//   DDS_SCLK      out  serial clock, idles low
//   DDS_SDIO      out  serial data, MSB first
//   DDS_CS_N      out  chip select, active low
//   DDS_IOUPDATE  out  I/O update strobe, active high
//   BUSY          out  high while a write sequence is running
//
// State | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for an accepted word that differs from the last written
// SHIFT | CS_N low, 40 bits clocked out on DDS_SCLK
// GAP   | SCLK low, CS_N still low for CLK_DIV cycles before release
// IOUPD | DDS_IOUPDATE high for IOUPD_CYCLES cycles (macro builds only)
// ---------------------------------------------------------------------------
module dds_ftw_writer #(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter logic [7:0]  FTW_ADDR      = 8'h03,
    parameter int unsigned IOUPD_CYCLES  = 4
) (
    input  logic        CLK_FPGA,
    input  logic        RST_N,
    input  logic [31:0] FTWhigh_32bit,
    output logic        DDS_SCLK,
    output logic        DDS_SDIO,
    output logic        DDS_CS_N,
    output logic        DDS_IOUPDATE,
    output logic        BUSY
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(CLK_DIV - 1);
    localparam int STB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [STB_W-1:0] STB_TC = STB_W'(STABLE_CYCLES - 1);
    localparam logic [5:0] LAST_BIT = 6'd39;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
`ifdef DDS_IOUPDATE_EN
    localparam logic [1:0] ST_IOUPD = 2'd3;
    localparam int IOU_W = (IOUPD_CYCLES > 1) ? $clog2(IOUPD_CYCLES) : 1;
    localparam logic [IOU_W-1:0] IOU_TC = IOU_W'(IOUPD_CYCLES - 1);
`endif

    logic [31:0]      sync1_q, sync2_q;
    logic [31:0]      last_seen_q, last_seen_d;
    logic [31:0]      last_written_q, last_written_d;
    logic [STB_W-1:0] stable_cnt_q, stable_cnt_d;
    logic [1:0]       state_q, state_d;
    logic [39:0]      shreg_q, shreg_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic             sclk_q, sclk_d;
    logic             cs_n_q, cs_n_d;
    logic             busy_q, busy_d;
    logic             accept;
`ifdef DDS_IOUPDATE_EN
    logic [IOU_W-1:0] iou_cnt_q, iou_cnt_d;
    logic             ioupd_q, ioupd_d;
`endif

    assign accept = (sync2_q == last_seen_q) && (stable_cnt_q == STB_TC) &&
                    (last_seen_q != last_written_q);

    always_comb begin
        last_seen_d    = last_seen_q;
        last_written_d = last_written_q;
        stable_cnt_d   = stable_cnt_q;
        state_d        = state_q;
        shreg_d        = shreg_q;
        div_cnt_d      = div_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        sclk_d         = sclk_q;
        cs_n_d         = cs_n_q;
        busy_d         = busy_q;
`ifdef DDS_IOUPDATE_EN
        iou_cnt_d      = iou_cnt_q;
        ioupd_d        = ioupd_q;
`endif

        // Filter runs in every state so a word that changes mid-write is
        // already qualified by the time IDLE is re-entered.
        if (sync2_q != last_seen_q) begin
            last_seen_d  = sync2_q;
            stable_cnt_d = '0;
        end else if (stable_cnt_q != STB_TC) begin
            stable_cnt_d = stable_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shreg_d        = {FTW_ADDR, last_seen_q};
                    last_written_d = last_seen_q;
                    cs_n_d         = 1'b0;
                    busy_d         = 1'b1;
                    sclk_d         = 1'b0;
                    bit_cnt_d      = '0;
                    div_cnt_d      = '0;
                    state_d        = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (div_cnt_q == DIV_TC) begin
                    div_cnt_d = '0;
                    sclk_d    = ~sclk_q;
                    // Shift only on the falling toggle so SDIO is held for
                    // a full half-period either side of each rising edge.
                    if (sclk_q) begin
                        shreg_d = {shreg_q[38:0], 1'b0};
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = ST_GAP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (div_cnt_q == DIV_TC) begin
                    div_cnt_d = '0;
                    cs_n_d    = 1'b1;
`ifdef DDS_IOUPDATE_EN
                    ioupd_d   = 1'b1;
                    iou_cnt_d = '0;
                    state_d   = ST_IOUPD;
`else
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
`endif
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
`ifdef DDS_IOUPDATE_EN
            ST_IOUPD: begin
                if (iou_cnt_q == IOU_TC) begin
                    ioupd_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    iou_cnt_d = iou_cnt_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_FPGA or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            last_seen_q    <= '0;
            last_written_q <= '0;
            stable_cnt_q   <= '0;
            state_q        <= ST_IDLE;
            shreg_q        <= '0;
            div_cnt_q      <= '0;
            bit_cnt_q      <= '0;
            sclk_q         <= 1'b0;
            cs_n_q         <= 1'b1;
            busy_q         <= 1'b0;
`ifdef DDS_IOUPDATE_EN
            iou_cnt_q      <= '0;
            ioupd_q        <= 1'b0;
`endif
        end else begin
            sync1_q        <= FTWhigh_32bit;
            sync2_q        <= sync1_q;
            last_seen_q    <= last_seen_d;
            last_written_q <= last_written_d;
            stable_cnt_q   <= stable_cnt_d;
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            div_cnt_q      <= div_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            sclk_q         <= sclk_d;
            cs_n_q         <= cs_n_d;
            busy_q         <= busy_d;
`ifdef DDS_IOUPDATE_EN
            iou_cnt_q      <= iou_cnt_d;
            ioupd_q        <= ioupd_d;
`endif
        end
    end

    // The shift register drains to zero, so SDIO rests low between frames.
    assign DDS_SDIO = shreg_q[39];
    assign DDS_SCLK = sclk_q;
    assign DDS_CS_N = cs_n_q;
    assign BUSY     = busy_q;
`ifdef DDS_IOUPDATE_EN
    assign DDS_IOUPDATE = ioupd_q;
`else
    assign DDS_IOUPDATE = 1'b0;
`endif

endmodule
